// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: access size encodings, I/O region decode and
// the memory controller state encoding.
package cpu_defs;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] IO_HI  = 2'b11;
  localparam int         IO_MSB = 17;
  localparam int         IO_LSB = 16;

  typedef enum logic [2:0] {
    MC_IDLE,
    MC_RD,
    MC_WR,
    MC_GAP,
    MC_DONE
  } mc_state_e;

  // Number of byte cycles for an access size; the illegal code 11 acts as a word.
  function automatic logic [2:0] size_len(input logic [1:0] sz);
    case (sz)
      SZ_B:    size_len = 3'd1;
      SZ_H:    size_len = 3'd2;
      SZ_W:    size_len = 3'd4;
      default: size_len = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-wide memory port controller shared by instruction fetch and load/store.
// Splits 1/2/4-byte accesses into byte cycles and absorbs the 1-cycle RAM read latency.
module mem_ctrl
  import cpu_defs::*;
#(
  parameter int ADDR_W    = 32,
  parameter int IO_WR_GAP = 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  localparam logic [7:0] GAP_INIT = 8'(IO_WR_GAP - 1);

  mc_state_e         state_q, state_d;
  logic              own_if_q, own_if_d;
  logic              we_q, we_d;
  logic              io_q, io_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        len_q, len_d;
  logic [2:0]        iss_q, iss_d;
  logic [2:0]        cap_q, cap_d;
  logic              pend_q, pend_d;
  logic [7:0]        gap_q, gap_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic [31:0]       if_hold_q, if_hold_d;
  logic [31:0]       ls_hold_q, ls_hold_d;
  logic              arb;
  logic              if_ok;

  always_comb begin
    state_d   = state_q;
    own_if_d  = own_if_q;
    we_d      = we_q;
    io_d      = io_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    len_d     = len_q;
    iss_d     = iss_q;
    cap_d     = cap_q;
    pend_d    = pend_q;
    gap_d     = gap_q;
    rbuf_d    = rbuf_q;
    if_hold_d = if_hold_q;
    ls_hold_d = ls_hold_q;
    mem_a     = '0;
    mem_dout  = '0;
    mem_wr    = 1'b0;
    if_done   = 1'b0;
    ls_done   = 1'b0;
    arb       = 1'b0;
    if_ok     = if_req && !if_flush;

    case (state_q)
      MC_IDLE: arb = rdy_in;

      MC_RD: begin
        if (own_if_q && if_flush) begin
          state_d = MC_IDLE;
        end else if (rdy_in) begin
          if (iss_q != len_q) begin
            mem_a = addr_q + ADDR_W'(iss_q);
            iss_d = iss_q + 3'd1;
          end
          // pend_q marks a byte issued last cycle with rdy high; its data is on mem_din now.
          pend_d = (iss_q != len_q);
          if (pend_q) begin
            rbuf_d[{cap_q[1:0], 3'b000} +: 8] = mem_din;
            cap_d = cap_q + 3'd1;
            if (cap_d == len_q) state_d = MC_DONE;
          end
        end else begin
          // A pause breaks the issue/capture pairing: rewind to the first uncaptured byte.
          iss_d  = cap_q;
          pend_d = 1'b0;
        end
      end

      MC_WR: begin
        if (rdy_in) begin
          mem_a    = addr_q + ADDR_W'(iss_q);
          mem_dout = wdata_q[{iss_q[1:0], 3'b000} +: 8];
          mem_wr   = 1'b1;
          iss_d    = iss_q + 3'd1;
          if (iss_d == len_q) begin
            state_d = (io_q && IO_WR_GAP > 0) ? MC_GAP : MC_DONE;
            gap_d   = GAP_INIT;
          end
        end
      end

      MC_GAP: begin
        if (rdy_in) begin
          if (gap_q == 8'd0) state_d = MC_DONE;
          else               gap_d   = gap_q - 8'd1;
        end
      end

      MC_DONE: begin
        if (own_if_q && if_flush) begin
          state_d = MC_IDLE;
        end else if (rdy_in) begin
          state_d = MC_IDLE;
          arb     = 1'b1;
          if (own_if_q) begin
            if_done   = 1'b1;
            if_hold_d = rbuf_q;
          end else begin
            ls_done = 1'b1;
            if (!we_q) ls_hold_d = rbuf_q;
          end
        end
      end

      default: state_d = MC_IDLE;
    endcase

    // Load/store wins over fetch; a flushed fetch is never granted.
    if (arb && (ls_req || if_ok)) begin
      own_if_d = !ls_req;
      we_d     = ls_req && ls_we;
      state_d  = (ls_req && ls_we) ? MC_WR : MC_RD;
      addr_d   = ls_req ? ls_addr : if_addr;
      wdata_d  = ls_wdata;
      len_d    = ls_req ? size_len(ls_size) : 3'd4;
      io_d     = ls_req && ls_we && (ls_addr[IO_MSB:IO_LSB] == IO_HI);
      iss_d    = 3'd0;
      cap_d    = 3'd0;
      pend_d   = 1'b0;
      rbuf_d   = '0;
    end
  end

  // Read data is presented straight from the assembly buffer in the done cycle, then held.
  assign if_data  = if_done ? rbuf_q : if_hold_q;
  assign ls_rdata = (ls_done && !we_q) ? rbuf_q : ls_hold_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= MC_IDLE;
      own_if_q  <= 1'b0;
      we_q      <= 1'b0;
      io_q      <= 1'b0;
      len_q     <= 3'd0;
      iss_q     <= 3'd0;
      cap_q     <= 3'd0;
      pend_q    <= 1'b0;
      gap_q     <= 8'd0;
      rbuf_q    <= '0;
      if_hold_q <= '0;
      ls_hold_q <= '0;
    end else begin
      state_q   <= state_d;
      own_if_q  <= own_if_d;
      we_q      <= we_d;
      io_q      <= io_d;
      len_q     <= len_d;
      iss_q     <= iss_d;
      cap_q     <= cap_d;
      pend_q    <= pend_d;
      gap_q     <= gap_d;
      rbuf_q    <= rbuf_d;
      if_hold_q <= if_hold_d;
      ls_hold_q <= ls_hold_d;
    end
  end

  always_ff @(posedge clk_in) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a vector table of load/store transactions plus
// hand-written sequences for arbitration, pause, flush, I/O gap and reset.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in;
  logic        if_req, if_flush, if_done;
  logic [31:0] if_addr, if_data;
  logic        ls_req, ls_we, ls_done;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  mem_ctrl #(.ADDR_W(32), .IO_WR_GAP(1)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: 256 KiB aliased over the address space, 1-cycle read latency.
  logic [7:0]  ram [0:262143];
  logic        pl_we = 1'b0;
  logic [17:0] pl_a = '0;
  logic [7:0]  pl_d = '0;
  int          wr_cnt = 0;
  logic [31:0] last_wr_a = '0;
  logic [7:0]  last_wr_d = '0;

  always @(posedge clk) begin
    if (pl_we)       ram[pl_a] <= pl_d;
    else if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
    mem_din <= ram[mem_a[17:0]];
    if (mem_wr) begin
      wr_cnt    <= wr_cnt + 1;
      last_wr_a <= mem_a;
      last_wr_d <= mem_dout;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
    end
  endtask

  task automatic preload(input logic [17:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_a  = a;
    pl_d  = d;
    pl_we = 1'b1;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic ls_run(input logic we, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd);
    lat = 0;
    rd  = '0;
    @(negedge clk);
    ls_req = 1'b1; ls_we = we; ls_size = sz; ls_addr = a; ls_wdata = wd;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (ls_done) begin
        lat = k;
        rd  = ls_rdata;
        break;
      end
    end
    ls_req = 1'b0;
    ls_we  = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          lat;
    int          nwr;
  } vec_t;

  vec_t vt [12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, ls_lat, if_lat, wr0;
    logic [31:0] dat, ls_dat, if_dat;
    logic        seen;

    rst_in = 1'b1; rdy_in = 1'b1;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    ls_req = 1'b0; ls_we = 1'b0; ls_size = '0; ls_addr = '0; ls_wdata = '0;

    vt[0]  = '{1'b0, 2'b10, 32'h0000_0200, 32'h0,         32'hD4C3_B2A1, 6, 0};
    vt[1]  = '{1'b0, 2'b01, 32'h0000_0201, 32'h0,         32'h0000_C3B2, 4, 0};
    vt[2]  = '{1'b0, 2'b00, 32'h0000_0203, 32'h0,         32'h0000_00D4, 3, 0};
    vt[3]  = '{1'b1, 2'b01, 32'h0000_0202, 32'h0000_BEEF, 32'h0,         3, 2};
    vt[4]  = '{1'b0, 2'b10, 32'h0000_0200, 32'h0,         32'hBEEF_B2A1, 6, 0};
    vt[5]  = '{1'b0, 2'b11, 32'h0000_0100, 32'h0,         32'h4433_2211, 6, 0};
    vt[6]  = '{1'b1, 2'b10, 32'h0000_0300, 32'h1234_5678, 32'h0,         5, 4};
    vt[7]  = '{1'b0, 2'b00, 32'h0000_0302, 32'h0,         32'h0000_0034, 3, 0};
    vt[8]  = '{1'b0, 2'b00, 32'h0003_0001, 32'h0,         32'h0000_005A, 3, 0};
    vt[9]  = '{1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0,         32'hAA99_8877, 6, 0};
    vt[10] = '{1'b1, 2'b00, 32'h0003_0002, 32'hFFFF_FF66, 32'h0,         3, 1};
    vt[11] = '{1'b0, 2'b00, 32'h0003_0002, 32'h0,         32'h0000_0066, 3, 0};

    preload(18'h00100, 8'h11); preload(18'h00101, 8'h22);
    preload(18'h00102, 8'h33); preload(18'h00103, 8'h44);
    preload(18'h00200, 8'hA1); preload(18'h00201, 8'hB2);
    preload(18'h00202, 8'hC3); preload(18'h00203, 8'hD4);
    preload(18'h30001, 8'h5A);
    preload(18'h3FFFE, 8'h77); preload(18'h3FFFF, 8'h88);
    preload(18'h00000, 8'h99); preload(18'h00001, 8'hAA);
    preload(18'h00002, 8'h01); preload(18'h00003, 8'h02);

    @(negedge clk);
    chk("rst mem_a", mem_a, 32'h0);
    chk("rst ctl", {28'h0, mem_wr, if_done, ls_done, 1'b0} | {24'h0, mem_dout}, 32'h0);
    chk("rst if_data", if_data, 32'h0);
    chk("rst ls_rdata", ls_rdata, 32'h0);
    rst_in = 1'b0;

    // Word fetch: byte addresses in order, done six cycles after acceptance.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100; lat = 0; dat = '0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k <= 4) chk($sformatf("fetch mem_a c%0d", k), mem_a, 32'h100 + k - 1);
      if (if_done) begin
        lat = k; dat = if_data; if_req = 1'b0;
        break;
      end
    end
    chk("fetch lat", lat, 6);
    chk("fetch data", dat, 32'h4433_2211);
    @(negedge clk);
    chk("fetch pulse width", {31'h0, if_done}, 32'h0);
    chk("fetch data hold", if_data, 32'h4433_2211);

    // Simultaneous requests: load first, fetch accepted in the load's done cycle.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h200;
    ls_lat = 0; if_lat = 0; ls_dat = '0; if_dat = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k <= 4) chk($sformatf("arb ls mem_a c%0d", k), mem_a, 32'h200 + k - 1);
      if (k == 8) chk("arb if byte1 mem_a", mem_a, 32'h1);
      if (ls_done) begin
        ls_lat = k; ls_dat = ls_rdata; ls_req = 1'b0;
      end
      if (if_done) begin
        if_lat = k; if_dat = if_data; if_req = 1'b0;
        break;
      end
    end
    chk("arb ls lat", ls_lat, 6);
    chk("arb ls data", ls_dat, 32'hD4C3_B2A1);
    chk("arb if lat", if_lat, 12);
    chk("arb if data", if_dat, 32'h0201_AA99);

    for (int i = 0; i < 12; i++) begin
      wr0 = wr_cnt;
      ls_run(vt[i].we, vt[i].sz, vt[i].addr, vt[i].wd, lat, dat);
      chk($sformatf("vec%0d lat", i), lat, vt[i].lat);
      if (!vt[i].we) chk($sformatf("vec%0d rdata", i), dat, vt[i].rd);
      chk($sformatf("vec%0d writes", i), wr_cnt - wr0, vt[i].nwr);
    end
    chk("ram 0x202", {24'h0, ram[18'h00202]}, 32'hEF);
    chk("ram 0x203", {24'h0, ram[18'h00203]}, 32'hBE);

    // I/O byte store: one gap cycle with the port idle before ls_done.
    wr0 = wr_cnt;
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b00; ls_addr = 32'h3_0000; ls_wdata = 32'h41;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) begin
        chk("io wr mem_a", mem_a, 32'h3_0000);
        chk("io wr mem_wr", {31'h0, mem_wr}, 32'h1);
      end
      if (k == 2) begin
        chk("io gap mem_a", mem_a, 32'h0);
        chk("io gap mem_wr", {31'h0, mem_wr}, 32'h0);
      end
      if (ls_done) begin
        lat = k; ls_req = 1'b0; ls_we = 1'b0;
        break;
      end
    end
    chk("io lat", lat, 3);
    chk("io write count", wr_cnt - wr0, 1);
    chk("io write addr", last_wr_a, 32'h3_0000);
    chk("io write byte", {24'h0, last_wr_d}, 32'h41);
    chk("io ram", {24'h0, ram[18'h30000]}, 32'h41);

    // Three-cycle pause right after byte 1 of a word load is issued.
    wr0 = wr_cnt;
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h100;
    lat = 0; dat = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1 rdy_in = !(k >= 3 && k <= 5);
      @(negedge clk);
      if (k == 6) chk("pause reissue mem_a", mem_a, 32'h101);
      if (ls_done) begin
        lat = k; dat = ls_rdata; ls_req = 1'b0;
        break;
      end
    end
    rdy_in = 1'b1;
    chk("pause lat", lat, 10);
    chk("pause data", dat, 32'h4433_2211);
    chk("pause writes", wr_cnt - wr0, 0);

    // Flush in the third cycle of a fetch; the waiting load goes next.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    seen = 1'b0; ls_lat = 0; ls_dat = '0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) begin
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b00; ls_addr = 32'h100;
      end
      if (k == 3) if_flush = 1'b1;
      if (k == 4) begin
        if_flush = 1'b0; if_req = 1'b0;
      end
      @(negedge clk);
      if (k == 4) chk("flush idle mem_a", mem_a, 32'h0);
      if (k == 5) chk("flush ls issue mem_a", mem_a, 32'h100);
      if (if_done) seen = 1'b1;
      if (ls_done && ls_lat == 0) begin
        ls_lat = k; ls_dat = ls_rdata; ls_req = 1'b0;
      end
    end
    chk("flush no if_done", {31'h0, seen}, 32'h0);
    chk("flush ls lat", ls_lat, 7);
    chk("flush ls data", ls_dat, 32'h11);

    // Reset in the middle of a word load: no done, outputs cleared.
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h200;
    seen = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) rst_in = 1'b1;
      if (k == 4) begin
        rst_in = 1'b0; ls_req = 1'b0;
      end
      @(negedge clk);
      if (k == 4) begin
        chk("midrst mem_a", mem_a, 32'h0);
        chk("midrst ls_rdata", ls_rdata, 32'h0);
      end
      if (ls_done) seen = 1'b1;
    end
    chk("midrst no ls_done", {31'h0, seen}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
